modexp_arbiter: RTL and testbench

Shares one Paillier modular-exponentiation/Montgomery engine between up to NUM_REQ requesters, such as the plant interface (encrypt/decrypt/rng) and the encrypted controller (setpoint/control/update).
- Round-robin grant; one job in flight at a time.
- Latches the winning operands, pulses the engine, routes the result back to the winner.
- Optional watchdog reports an engine that never finishes.
- Sits between the requesters and the single shared engine instance at the top level.

---
 rtl/paillier_pkg.sv | 28 ++
 rtl/modexp_arbiter_if.sv | 27 ++
 rtl/modexp_arbiter_rr_select.sv | 30 +++
 rtl/modexp_arbiter.sv | 123 ++++++++++++
 tb/tb_modexp_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier modexp engine and its arbiter:
// task encodings, the engine datapath width, the arbiter state encoding
// and a small width helper.
package paillier_pkg;

  localparam int unsigned PAILLIER_DATA_W = 528;
  localparam int unsigned MODEXP_TASK_W   = 2;

  typedef enum logic [MODEXP_TASK_W-1:0] {
    MODEXP_EXP            = 2'b00,
    MODEXP_MULT_N2        = 2'b01,
    MODEXP_MULT_N2_PLUS_2 = 2'b10,
    MODEXP_MULT_N         = 2'b11
  } modexp_task_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // clog2(n) with a floor of 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modexp_arbiter_if.sv
// Requester-side bus of the modexp arbiter.
//   master : requesters (drive req_*, receive req_ready and rsp_*)
//   slave  : the arbiter
interface modexp_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 528,
  parameter int unsigned TASK_W  = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*TASK_W-1:0] req_task;
  logic [NUM_REQ*DATA_W-1:0] req_base;
  logic [NUM_REQ*DATA_W-1:0] req_exp;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_error;

  modport master (
    output req_valid, req_task, req_base, req_exp,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_task, req_base, req_exp,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/modexp_arbiter_rr_select.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted most recently
//   grant      : first requesting index after last_grant (wrapping)
//   any_req    : at least one request is present
module rr_select #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  int unsigned cand;

  // Walk offsets farthest-first so the nearest requester after last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    cand    = 0;
    for (int unsigned ofs = NUM_REQ; ofs > 0; ofs--) begin
      cand = 32'(last_grant) + ofs;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[IDX_W'(cand)]) grant = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/modexp_arbiter.sv
// Shares one modexp/Montgomery engine between NUM_REQ requesters.
// Round-robin grant, one job in flight, optional watchdog.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester bus (req_valid/ready/task/base/exp, rsp_valid/data/error)
//   eng_start  : one-cycle engine start pulse
//   eng_task/base/exp : operands latched at accept
//   eng_done, eng_result : engine completion and result
module modexp_arbiter
  import paillier_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_W         = PAILLIER_DATA_W,
  parameter int unsigned TASK_W         = MODEXP_TASK_W,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  modexp_arbiter_if.slave    bus,
  output logic               eng_start,
  output logic [TASK_W-1:0]  eng_task,
  output logic [DATA_W-1:0]  eng_base,
  output logic [DATA_W-1:0]  eng_exp,
  input  logic               eng_done,
  input  logic [DATA_W-1:0]  eng_result
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned CNT_W = idx_width(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, grant_q, sel_idx;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  ready_c;
  logic                any_req;
  logic                timeout_c;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (sel_idx),
    .any_req    (any_req)
  );

  assign timeout_c     = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
  assign bus.req_ready = ready_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Next state and the combinational accept.
  always_comb begin
    state_d = state_q;
    ready_c = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          ready_c = NUM_REQ'(1) << sel_idx;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      // eng_done is checked first so it wins on the expiry cycle.
      ARB_WAIT:  if (eng_done || timeout_c) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Operand latches, response capture, watchdog and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      grant_q       <= '0;
      cnt_q         <= '0;
      eng_start     <= 1'b0;
      eng_task      <= '0;
      eng_base      <= '0;
      eng_exp       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      eng_start     <= 1'b0;
      bus.rsp_valid <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q   <= sel_idx;
            eng_task  <= bus.req_task[32'(sel_idx)*TASK_W +: TASK_W];
            eng_base  <= bus.req_base[32'(sel_idx)*DATA_W +: DATA_W];
            eng_exp   <= bus.req_exp[32'(sel_idx)*DATA_W +: DATA_W];
            eng_start <= 1'b1;
          end
        end
        ARB_ISSUE: cnt_q <= '0;
        ARB_WAIT: begin
          if (eng_done) begin
            bus.rsp_data  <= eng_result;
            bus.rsp_error <= 1'b0;
            bus.rsp_valid <= NUM_REQ'(1) << grant_q;
          end else if (timeout_c) begin
            bus.rsp_data  <= '0;
            bus.rsp_error <= 1'b1;
            bus.rsp_valid <= NUM_REQ'(1) << grant_q;
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ARB_RESP: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
`timescale 1ns/1ps
module tb_modexp_arbiter;
  import paillier_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned DW = PAILLIER_DATA_W;
  localparam int unsigned TW = 2;
  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  modexp_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .TASK_W(TW)) bus ();

  logic          eng_start;
  logic [TW-1:0] eng_task;
  logic [DW-1:0] eng_base, eng_exp;
  logic          eng_done;
  logic [DW-1:0] eng_result;

  modexp_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .TASK_W(TW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .eng_start  (eng_start),
    .eng_task   (eng_task),
    .eng_base   (eng_base),
    .eng_exp    (eng_exp),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int r);
    return NR'(1) << r;
  endfunction

  // Engine model: result = base + exp after eng_delay cycles; mode 1 never answers.
  int   eng_mode  = 0;
  int   eng_delay = 10;
  bit   stray     = 1'b0;
  bit   pend      = 1'b0;
  int   ecnt      = 0;
  logic [DW-1:0] eres;

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    eres       = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst) pend = 1'b0;
      else if (eng_start) begin
        pend = (eng_mode == 0);
        ecnt = eng_delay;
        eres = eng_base + eng_exp;
      end else if (pend) begin
        ecnt--;
        if (ecnt == 0) begin
          pend       = 1'b0;
          eng_done   = 1'b1;
          eng_result = eres;
        end
      end
      if (stray) begin
        stray      = 1'b0;
        eng_done   = 1'b1;
        eng_result = DW'(32'hDEAD_BEEF);
      end
    end
  end

  // Scoreboard: expected responses pushed at accept, popped by the monitor.
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", DW'(bus.rsp_valid), '0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", DW'(bus.rsp_valid), DW'(onehot(e.idx)));
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_error", DW'(bus.rsp_error), DW'(e.err));
        check("rsp_cycle", DW'(cyc), DW'(e.cyc));
      end
    end
  end

  // Job tables with hand-computed results (base + exp).
  logic [TW-1:0] jt [NR][4];
  logic [DW-1:0] jb [NR][4];
  logic [DW-1:0] je [NR][4];
  logic [DW-1:0] jr [NR][4];
  int  nj [NR];
  int  order_q[$];
  bit  no_expect = 1'b0;

  task automatic set_job(input int r, input int k, input logic [TW-1:0] t,
                         input logic [31:0] b, input logic [31:0] x, input logic [31:0] res);
    jt[r][k] = t;
    jb[r][k] = DW'(b);
    je[r][k] = DW'(x);
    jr[r][k] = DW'(res);
  endtask

  task automatic load(input int r, input int k);
    bus.req_task[r*TW +: TW] = jt[r][k];
    bus.req_base[r*DW +: DW] = jb[r][k];
    bus.req_exp[r*DW +: DW]  = je[r][k];
  endtask

  // Present the job tables; returns at the negedge after the last accept.
  task automatic run_jobs();
    int   k[NR];
    bit   upd[NR];
    int   budget;
    exp_t e;
    budget = 600;
    for (int r = 0; r < NR; r++) begin
      k[r] = 0;
      upd[r] = 1'b0;
      if (nj[r] > 0) begin
        load(r, 0);
        bus.req_valid[r] = 1'b1;
      end
    end
    while ((k[0] < nj[0] || k[1] < nj[1]) && budget > 0) begin
      #1;
      for (int r = 0; r < NR; r++) begin
        if (bus.req_ready[r]) begin
          check("req_ready_onehot", DW'(bus.req_ready), DW'(onehot(r)));
          order_q.push_back(r);
          if (!no_expect) begin
            e.idx = r;
            if (eng_mode != 0 || eng_delay > int'(TO)) begin
              e.data = '0;
              e.err  = 1'b1;
              e.cyc  = cyc + int'(TO) + 2;
            end else begin
              e.data = jr[r][k[r]];
              e.err  = 1'b0;
              e.cyc  = cyc + eng_delay + 2;
            end
            sb.push_back(e);
          end
          k[r]++;
          upd[r] = 1'b1;
        end
      end
      @(negedge clk);
      budget--;
      for (int r = 0; r < NR; r++) begin
        if (upd[r]) begin
          upd[r] = 1'b0;
          if (k[r] < nj[r]) load(r, k[r]);
          else bus.req_valid[r] = 1'b0;
        end
      end
    end
    if (budget == 0) check("accept_timeout", DW'(k[0] + k[1]), DW'(nj[0] + nj[1]));
    bus.req_valid = '0;
  endtask

  task automatic drain();
    int b;
    b = 200;
    while (sb.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (sb.size() != 0) begin
      check("response_timeout", DW'(sb.size()), '0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_task  = '0;
    bus.req_base  = '0;
    bus.req_exp   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_req_ready", DW'(bus.req_ready), '0);
    check("reset_rsp_valid", DW'(bus.rsp_valid), '0);
    check("reset_rsp_data", bus.rsp_data, '0);
    check("reset_rsp_error", DW'(bus.rsp_error), '0);
    check("reset_eng_start", DW'(eng_start), '0);
    check("reset_eng_base", eng_base, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single job from requester 1
    eng_mode = 0; eng_delay = 10;
    nj = '{0, 1};
    set_job(1, 0, MODEXP_MULT_N2, 32'h1234, 32'h5, 32'h1239);
    order_q.delete();
    run_jobs();
    check("issue_eng_start", DW'(eng_start), DW'(1'b1));
    check("issue_eng_task", DW'(eng_task), DW'(2'b01));
    check("issue_eng_base", eng_base, DW'(16'h1234));
    check("issue_eng_exp", eng_exp, DW'(4'h5));
    drain();
    check("hold_eng_base", eng_base, DW'(16'h1234));

    // Fairness after reset: both held for two jobs each
    do_reset();
    eng_delay = 4;
    nj = '{2, 2};
    set_job(0, 0, MODEXP_EXP,            32'h100, 32'h1, 32'h101);
    set_job(0, 1, MODEXP_MULT_N,         32'h300, 32'h3, 32'h303);
    set_job(1, 0, MODEXP_MULT_N2_PLUS_2, 32'h200, 32'h2, 32'h202);
    set_job(1, 1, MODEXP_MULT_N2,        32'h400, 32'h4, 32'h404);
    order_q.delete();
    run_jobs();
    drain();
    check("fair_count", DW'(order_q.size()), DW'(4));
    if (order_q.size() == 4) begin
      check("fair_order0", DW'(order_q[0]), DW'(0));
      check("fair_order1", DW'(order_q[1]), DW'(1));
      check("fair_order2", DW'(order_q[2]), DW'(0));
      check("fair_order3", DW'(order_q[3]), DW'(1));
    end

    // Watchdog: engine never answers
    eng_mode = 1;
    nj = '{1, 0};
    set_job(0, 0, MODEXP_EXP, 32'h10, 32'h1, 32'h0);
    run_jobs();
    drain();
    stray = 1'b1;
    repeat (5) @(negedge clk);
    check("timeout_hold_error", DW'(bus.rsp_error), DW'(1'b1));
    check("timeout_hold_data", bus.rsp_data, '0);

    // Next job after the stray done proceeds normally
    eng_mode = 0; eng_delay = 3;
    nj = '{0, 1};
    set_job(1, 0, MODEXP_MULT_N, 32'h20, 32'h3, 32'h23);
    run_jobs();
    drain();
    check("rsp_data_hold", bus.rsp_data, DW'(8'h23));

    // Done one cycle past expiry: timeout, late done ignored
    eng_delay = 21;
    nj = '{0, 1};
    set_job(1, 0, MODEXP_EXP, 32'h50, 32'h5, 32'h0);
    run_jobs();
    drain();

    // Done on the expiry cycle: done wins
    eng_delay = 20;
    nj = '{1, 0};
    set_job(0, 0, MODEXP_MULT_N2, 32'h40, 32'h4, 32'h44);
    run_jobs();
    drain();

    // Reset five cycles after eng_start: job abandoned
    eng_delay = 10;
    no_expect = 1'b1;
    nj = '{0, 1};
    set_job(1, 0, MODEXP_EXP, 32'h60, 32'h6, 32'h66);
    run_jobs();
    no_expect = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_eng_start", DW'(eng_start), '0);
    check("midrst_eng_task", DW'(eng_task), '0);
    check("midrst_eng_base", eng_base, '0);
    check("midrst_eng_exp", eng_exp, '0);
    check("midrst_rsp_data", bus.rsp_data, '0);
    check("midrst_rsp_error", DW'(bus.rsp_error), '0);
    stray = 1'b1;
    repeat (12) @(negedge clk);
    nj = '{1, 1};
    set_job(0, 0, MODEXP_MULT_N2, 32'h70, 32'h7, 32'h77);
    set_job(1, 0, MODEXP_MULT_N,  32'h80, 32'h8, 32'h88);
    order_q.delete();
    run_jobs();
    drain();
    check("post_rst_count", DW'(order_q.size()), DW'(2));
    if (order_q.size() == 2) begin
      check("post_rst_first", DW'(order_q[0]), DW'(0));
      check("post_rst_second", DW'(order_q[1]), DW'(1));
    end

    // Withdrawn request during WAIT
    eng_delay = 10;
    nj = '{1, 0};
    set_job(0, 0, MODEXP_EXP, 32'h90, 32'h9, 32'h99);
    set_job(1, 0, MODEXP_MULT_N, 32'hA0, 32'hA, 32'hAA);
    run_jobs();
    @(negedge clk);
    load(1, 0);
    bus.req_valid[1] = 1'b1;
    #1;
    check("withdraw_ready_wait", DW'(bus.req_ready), '0);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    #1;
    check("withdraw_ready_drop", DW'(bus.req_ready), '0);
    drain();
    check("withdraw_ready_idle", DW'(bus.req_ready), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
